signed_addsub_serial: RTL

SIGNED_ADDSUB_SERIAL -- requirements
Module: signed_addsub_serial

---
 rtl/signed_addsub_serial_pkg.sv | 22 ++
 rtl/signed_addsub_serial_if.sv | 29 ++
 rtl/fa.sv | 15 +
 rtl/signed_addsub_serial.sv | 124 ++++++++++++
 4 files changed

// File: rtl/signed_addsub_serial_pkg.sv
// Shared types and constants for the bit-serial signed add/subtract unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package signed_addsub_pkg;

    // Default operand/result width.
    localparam int DEF_N = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Each negated operand is fed in one's-complement form. The missing +1
    // for each one rides in the initial carry, so the carry starts at 0, 1 or 2.
    function automatic logic [1:0] carry_init(input logic [1:0] sign);
        return {1'b0, sign[1]} + {1'b0, sign[0]};
    endfunction

endpackage

// File: rtl/signed_addsub_serial_if.sv
// Request/result bundle between a requester and signed_addsub_serial.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the unit is idle.
interface signed_addsub_serial_if
    import signed_addsub_pkg::*;
#(
    parameter int N = DEF_N
);

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   sign;
    logic         busy;
    logic         done;
    logic [N-1:0] res_signed;
    logic         ovf;

    modport master (
        output start, a, b, sign,
        input  busy, done, res_signed, ovf
    );

    modport slave (
        input  start, a, b, sign,
        output busy, done, res_signed, ovf
    );

endinterface

// File: rtl/fa.sv
// One-bit full adder library cell.
// Latency: purely combinational.
// Backpressure: n/a.
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/signed_addsub_serial.sv
// Bit-serial (+/-A)+(+/-B) mod 2^N with signed overflow flag.
// Latency: done pulses N+2 edges after the accepting edge; one op per N+4 cycles.
// Backpressure: start is ignored while busy or in the done cycle; no queueing.
module signed_addsub_serial
    import signed_addsub_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic                   clk,
    input  logic                   rst_n,
    signed_addsub_serial_if.slave  bus
);

    // Two guard bits keep the full sum of two N-bit magnitudes representable.
    localparam int               W    = N + 2;
    localparam int               CW   = $clog2(W);
    localparam logic [CW-1:0]    LAST = CW'(N + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [1:0]      carry_q, carry_d;
    logic [W-1:0]    opa_q,   opa_d;
    logic [W-1:0]    opb_q,   opb_d;
    logic [W-1:0]    acc_q,   acc_d;
    logic [N-1:0]    res_q,   res_d;
    logic            ovf_q,   ovf_d;

    logic [W-1:0]    sext_a;
    logic [W-1:0]    sext_b;
    logic            sum_bit;
    logic            fa_co;

    assign sext_a = {{2{bus.a[N-1]}}, bus.a};
    assign sext_b = {{2{bus.b[N-1]}}, bus.b};

    // The sum bit only depends on carry[0]; carry[1] is folded in below.
    fa u_fa (
        .a_i  (opa_q[0]),
        .b_i  (opb_q[0]),
        .ci_i (carry_q[0]),
        .s_o  (sum_bit),
        .co_o (fa_co)
    );

    // Next-state and datapath: load on accept, one bit per RUN cycle, publish on last bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    carry_d = carry_init(bus.sign);
                    opa_d   = bus.sign[1] ? ~sext_a : sext_a;
                    opb_d   = bus.sign[0] ? ~sext_b : sext_b;
                    acc_d   = '0;
                end
            end
            RUN: begin
                acc_d   = {sum_bit, acc_q[W-1:1]};
                carry_d = {1'b0, fa_co} + {1'b0, carry_q[1]};
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    res_d   = acc_d[N-1:0];
                    // Top three sum bits disagree exactly when the value leaves N-bit range.
                    ovf_d   = (|acc_d[W-1:N-1]) & ~(&acc_d[W-1:N-1]);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            carry_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.res_signed = res_q;
    assign bus.ovf        = ovf_q;

endmodule
